regfile_port_seq: RTL and testbench
===================================

# regfile_port_seq

Operand sequencer in front of the single-port register file. It accepts one instruction-level request per handshake: read two source registers, then optionally write one destination. It serialises these accesses onto the register file's single address/data/mode port and returns both operands on a valid/ready response channel. It sits between decode and the register file and owns every register-file access.

## Interface
- DATA_WIDTH, 8, register data width
- ADDR_WIDTH, 3, register index width (2**ADDR_WIDTH registers)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  sequencer can accept a request
- req_rs1  in  ADDR_WIDTH  source register 1
- req_rs2  in  ADDR_WIDTH  source register 2
- req_rd  in  ADDR_WIDTH  destination register
- req_we  in  1  perform a write of req_wdata to req_rd
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  operands valid
- rsp_ready  in  1  consumer accepts operands
- rsp_op1  out  DATA_WIDTH  value of rs1
- rsp_op2  out  DATA_WIDTH  value of rs2
- rf_address  out  ADDR_WIDTH  register file address; the register file registers it on the next edge
- rf_i_data  out  DATA_WIDTH  register file write data; registered by the register file on the next edge
- rf_mode  out  1  write strobe; not registered by the register file, so it must be high in the cycle after the address/data were presented
- rf_o_data  in  DATA_WIDTH  read data for the address the register file registered on the previous edge

## Operation
- All outputs are registered.
- Request fields are latched on the accept edge (req_valid && req_ready).
- FSM states: IDLE, A1, A2, A3, WM, RSP.
- IDLE
  - req_ready=1.
  - On accept, go to A1.
- A1
  - rf_address=rs1.
  - Go to A2, or to A3 if the skip rule in Configuration applies.
- A2
  - rf_address=rs2; rf_o_data holds the rs1 value.
  - op1 is captured at the end of A2. Go to A3.
- A3
  - rf_o_data holds the rs2 value; op2 is captured at the end of A3.
  - If we=1: rf_address=rd and rf_i_data=wdata, then go to WM.
  - If we=0: rf_address holds, then go to RSP.
- WM
  - rf_mode=1 for exactly this one cycle. The write commits at the edge ending WM. Go to RSP.
- RSP
  - rsp_valid=1; rsp_op1/rsp_op2 are stable.
  - On rsp_ready, go to IDLE.
- rf_mode is 0 in every state except WM.
- Reads always occur before the write. If rd equals rs1 or rs2, the response returns the pre-write value.
- A request whose read follows a previous request's write sees the written value.
- rs1==rs2 is legal.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_op1=0, rsp_op2=0, rf_address=0, rf_i_data=0, rf_mode=0.
- Latency from the accept edge to rsp_valid high:
  - 4 cycles with we=0.
  - 5 cycles with we=1.
- req_ready is 1 only in IDLE. It drops the cycle after accept and no request is queued.
- Minimum request spacing with rsp_ready tied high:
  - 5 cycles with we=0.
  - 6 cycles with we=1.
- With rsp_ready low, RSP holds indefinitely and all outputs stay stable.
- Reset mid-operation: the FSM returns to IDLE at the reset edge and the latched request is discarded.
  - Reset asserted before WM: no write occurs.
  - Reset asserted during WM: the write at that edge still commits, because rf_mode was already high for that cycle.
- req_* are ignored outside IDLE.

## Configuration
- Macro: RF_SEQ_DUP_READ_SKIP_EN.
- Defined: when rs1==rs2, A1 goes directly to A3.
  - rf_address stays rs1.
  - At the end of A3, both op1 and op2 are captured from rf_o_data.
  - Latency drops by one cycle: 3 with we=0, 4 with we=1.
- Undefined: A2 is always visited; rs1==rs2 requests take the normal latency.

## Test plan
- Write then read: request rs1=0, rs2=0, rd=3, we=1, wdata=0x5A; then request rs1=3, rs2=3, we=0 -> second response op1=op2=0x5A. rf_mode is high for exactly one cycle in total.
- Read-before-write: preload r2=0x11; request rs1=2, rs2=5, rd=2, we=1, wdata=0xEE -> op1=0x11. A following read of r2 -> 0xEE.
- Latency/skip: rs1=1, rs2=4, we=0 -> rsp_valid 4 cycles after accept. rs1=rs2=4, we=0 -> 4 cycles without the macro, 3 with it; both ops equal r4.
- Backpressure: hold rsp_ready=0 for 3 cycles in RSP -> rsp_valid, ops and req_ready=0 are stable. A new req_valid is ignored until IDLE.
- Reset in A2 of a we=1 request with wdata=0x77 to r6 (r6=0x00) -> all outputs at reset values next cycle, and a later read of r6 returns 0x00.
- we=0 request stream of 10 requests -> rf_mode never asserted; each op matches the register-model value.

Source files
------------

// File: rtl/regfile_port_seq.sv
// Operand sequencer: serialises rs1/rs2 reads and an optional rd write onto a single-port register file.
// Optional feature macro: RF_SEQ_DUP_READ_SKIP_EN (skip the second read when rs1 == rs2).
module regfile_port_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  input  logic [ADDR_WIDTH-1:0] req_rd,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_op1,
  output logic [DATA_WIDTH-1:0] rsp_op2,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic [DATA_WIDTH-1:0] rf_i_data,
  output logic                  rf_mode,
  input  logic [DATA_WIDTH-1:0] rf_o_data
);

  typedef enum logic [2:0] {IDLE, A1, A2, A3, WM, RSP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
`ifdef RF_SEQ_DUP_READ_SKIP_EN
  logic                  dup_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_op1    <= '0;
      rsp_op2    <= '0;
      rf_address <= '0;
      rf_i_data  <= '0;
      rf_mode    <= 1'b0;
      rs2_q      <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
`ifdef RF_SEQ_DUP_READ_SKIP_EN
      dup_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rs2_q      <= req_rs2;
            rd_q       <= req_rd;
            we_q       <= req_we;
            wdata_q    <= req_wdata;
`ifdef RF_SEQ_DUP_READ_SKIP_EN
            dup_q      <= (req_rs1 == req_rs2);
`endif
            rf_address <= req_rs1;
            req_ready  <= 1'b0;
            state      <= A1;
          end
        end
        A1: begin
`ifdef RF_SEQ_DUP_READ_SKIP_EN
          // Duplicate source: the rs1 read already covers rs2, go straight to the capture state.
          if (dup_q) begin
            if (we_q) begin
              rf_address <= rd_q;
              rf_i_data  <= wdata_q;
            end
            state <= A3;
          end else begin
            rf_address <= rs2_q;
            state      <= A2;
          end
`else
          rf_address <= rs2_q;
          state      <= A2;
`endif
        end
        A2: begin
          rsp_op1 <= rf_o_data;
          if (we_q) begin
            rf_address <= rd_q;
            rf_i_data  <= wdata_q;
          end
          state <= A3;
        end
        A3: begin
          rsp_op2 <= rf_o_data;
`ifdef RF_SEQ_DUP_READ_SKIP_EN
          if (dup_q) rsp_op1 <= rf_o_data;
`endif
          if (we_q) begin
            rf_mode <= 1'b1;
            state   <= WM;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        WM: begin
          rf_mode   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rf_mode   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_seq.sv
// Directed bench for regfile_port_seq with a behavioural single-port register file attached.
module tb_regfile_port_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_rs1 = '0, req_rs2 = '0, req_rd = '0;
  logic       req_we = 1'b0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_op1, rsp_op2;
  logic [2:0] rf_address;
  logic [7:0] rf_i_data;
  logic       rf_mode;
  logic [7:0] rf_o_data;

  int tests_run = 0;
  int tests_failed = 0;
  int mode_cycles = 0;

`ifdef RF_SEQ_DUP_READ_SKIP_EN
  localparam int DUP_LAT = 3;
`else
  localparam int DUP_LAT = 4;
`endif

  regfile_port_seq #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op1(rsp_op1), .rsp_op2(rsp_op2),
    .rf_address(rf_address), .rf_i_data(rf_i_data),
    .rf_mode(rf_mode), .rf_o_data(rf_o_data)
  );

  always #5 clk = ~clk;

  // Register file: address/data registered, write strobe used unregistered.
  logic [2:0] rf_aq = '0;
  logic [7:0] rf_dq = '0;
  logic [7:0] rf_mem [8] = '{default: 8'h00};
  always @(posedge clk) begin
    rf_aq <= rf_address;
    rf_dq <= rf_i_data;
    if (rf_mode) rf_mem[rf_aq] <= rf_dq;
  end
  assign rf_o_data = rf_mem[rf_aq];

  always @(negedge clk) if (rf_mode) mode_cycles++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is first seen.
  // lat counts cycles with the accept cycle as cycle 0.
  task automatic do_req(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                        input logic we, input logic [7:0] wd, output int lat);
    int n = 0;
    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_we = we; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic rsp_done();
    rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0] model [8];
  logic [2:0] s1 [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd7, 3'd1, 3'd2, 3'd5};
  logic [2:0] s2 [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd3, 3'd1, 3'd4, 3'd2, 3'd0};

  initial begin
    int lat;
    int m0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_op1", rsp_op1, 0);
    check("rst_op2", rsp_op2, 0);
    check("rst_rf_address", rf_address, 0);
    check("rst_rf_i_data", rf_i_data, 0);
    check("rst_rf_mode", rf_mode, 0);

    // Write r3 = 0x5A, then read it back on both ports.
    do_req(3'd0, 3'd0, 3'd3, 1'b1, 8'h5A, lat);
    check("wr_lat", lat, DUP_LAT + 1);
    check("wr_op1", rsp_op1, 8'h00);
    rsp_done();
    check("wr_mode_once", mode_cycles, 1);
    do_req(3'd3, 3'd3, 3'd0, 1'b0, 8'h00, lat);
    check("rd3_lat", lat, DUP_LAT);
    check("rd3_op1", rsp_op1, 8'h5A);
    check("rd3_op2", rsp_op2, 8'h5A);
    rsp_done();

    // Preload r2, r4, r1.
    do_req(3'd0, 3'd1, 3'd2, 1'b1, 8'h11, lat); check("pre2_lat", lat, 5); rsp_done();
    do_req(3'd0, 3'd1, 3'd4, 1'b1, 8'h44, lat); rsp_done();
    do_req(3'd0, 3'd2, 3'd1, 1'b1, 8'h21, lat); check("pre1_op2", rsp_op2, 8'h11); rsp_done();

    // Read before write on the same register.
    do_req(3'd2, 3'd5, 3'd2, 1'b1, 8'hEE, lat);
    check("rbw_op1", rsp_op1, 8'h11);
    check("rbw_op2", rsp_op2, 8'h00);
    rsp_done();
    do_req(3'd2, 3'd0, 3'd0, 1'b0, 8'h00, lat);
    check("rbw_after", rsp_op1, 8'hEE);
    rsp_done();

    // Latency and duplicate-source read.
    do_req(3'd1, 3'd4, 3'd0, 1'b0, 8'h00, lat);
    check("lat_we0", lat, 4);
    check("lat_op1", rsp_op1, 8'h21);
    check("lat_op2", rsp_op2, 8'h44);
    rsp_done();
    do_req(3'd4, 3'd4, 3'd0, 1'b0, 8'h00, lat);
    check("dup_lat", lat, DUP_LAT);
    check("dup_op1", rsp_op1, 8'h44);
    check("dup_op2", rsp_op2, 8'h44);
    rsp_done();

    // Backpressure with a competing request held during RSP.
    rsp_ready = 1'b0;
    do_req(3'd1, 3'd2, 3'd0, 1'b0, 8'h00, lat);
    check("bp_op1", rsp_op1, 8'h21);
    check("bp_op2", rsp_op2, 8'hEE);
    req_rs1 = 3'd6; req_rs2 = 3'd7; req_rd = 3'd6; req_we = 1'b1; req_wdata = 8'h99;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_ready", req_ready, 0);
      check("bp_hold", {rsp_op1, rsp_op2, 5'(rf_address)}, {8'h21, 8'hEE, 5'd2});
    end
    req_valid = 1'b0;
    rsp_done();
    check("bp_idle", {31'd0, req_ready}, 1);
    check("bp_mode", mode_cycles, 5);

    // Reset in A2 of a write to r6.
    m0 = mode_cycles;
    req_rs1 = 3'd0; req_rs2 = 3'd1; req_rd = 3'd6; req_we = 1'b1; req_wdata = 8'h77;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mr_ready", req_ready, 1);
    check("mr_valid", rsp_valid, 0);
    check("mr_ops", {rsp_op1, rsp_op2}, 16'h0000);
    check("mr_rf", {rf_address, rf_i_data, rf_mode}, 12'h000);
    @(negedge clk);
    do_req(3'd6, 3'd6, 3'd0, 1'b0, 8'h00, lat);
    check("mr_r6", rsp_op1, 8'h00);
    rsp_done();
    check("mr_no_write", mode_cycles, m0);

    // Read-only stream against the expected register contents.
    model = '{8'h00, 8'h21, 8'hEE, 8'h5A, 8'h44, 8'h00, 8'h00, 8'h00};
    m0 = mode_cycles;
    for (int i = 0; i < 10; i++) begin
      do_req(s1[i], s2[i], 3'd0, 1'b0, 8'h00, lat);
      check($sformatf("st_op1_%0d", i), rsp_op1, model[s1[i]]);
      check($sformatf("st_op2_%0d", i), rsp_op2, model[s2[i]]);
      rsp_done();
    end
    check("st_no_mode", mode_cycles, m0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
